// File: rtl/m68k_bus_pkg.sv
// Shared encodings for the MC68010-style bus master: access sizes, response
// error codes and the bus-cycle state machine states.
package m68k_bus_pkg;

  localparam logic [1:0] OP_BYTE = 2'd0;
  localparam logic [1:0] OP_WORD = 2'd1;
  localparam logic [1:0] OP_LONG = 2'd2;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_BERR = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_ADDR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ASRT,
    S_WAIT,
    S_DATA,
    S_NEG,
    S_RECOV,
    S_GRANT,
    S_RESP
  } state_e;

endpackage

// File: rtl/m68k_bus_wdog.sv
// Wait-state watchdog: cleared before a WAIT phase, counts while enabled and
// flags expiry during the TIMEOUT-th counted cycle.
module m68k_bus_wdog #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/m68k_bus_master.sv
// MC68010-style asynchronous bus master: runs byte/word/long host commands as
// P_* bus cycles with DTACK/BERR/timeout termination and BR/BG arbitration.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              C100,
  input  logic              RESET_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_fc,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-2:0] P_A,
  output logic [2:0]        P_FC,
  output logic              P_AS_n,
  output logic              P_UDS_n,
  output logic              P_LDS_n,
  output logic              P_RW_n,
  output logic              P_bus_oe,
  output logic [15:0]       P_D_out,
  output logic              P_D_oe,
  input  logic [15:0]       P_D_in,
  input  logic              P_DTACK_n,
  input  logic              P_BERR_n,
  input  logic              P_BR_n,
  input  logic              P_BGACK_n,
  output logic              P_BG_n
);

  state_e            state_q, state_d;
  logic              br_q;
  logic [1:0]        op_q, op_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        fc_q, fc_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              half_q, half_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wd_expired;
  logic              strobe;
  logic [7:0]        rd_lane;

  m68k_bus_wdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk     (C100),
    .rst_n   (RESET_n),
    .clr     (state_q == S_ASRT),
    .en      (state_q == S_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    fc_d      = fc_q;
    wdata_d   = wdata_q;
    half_d    = half_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    cmd_ready = 1'b0;
    rd_lane   = addr_q[0] ? P_D_in[7:0] : P_D_in[15:8];
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = !br_q;
        // A pending bus request wins over a command presented the same cycle.
        if (br_q) begin
          state_d = S_GRANT;
        end else if (cmd_valid) begin
          op_d    = (cmd_op == 2'd3) ? OP_WORD : cmd_op;
          rd_d    = cmd_read;
          addr_d  = cmd_addr;
          fc_d    = cmd_fc;
          wdata_d = cmd_wdata;
          half_d  = 1'b0;
          rdata_d = '0;
          err_d   = ERR_OK;
          if ((cmd_op != OP_BYTE) && cmd_addr[0]) begin
            err_d   = ERR_ADDR;
            state_d = S_RESP;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR:  state_d = S_ASRT;
      S_ASRT:  state_d = S_WAIT;
      S_WAIT: begin
        if (!P_BERR_n) begin
          err_d   = ERR_BERR;
          state_d = S_NEG;
        end else if (!P_DTACK_n) begin
          state_d = S_DATA;
        end else if (wd_expired) begin
          err_d   = ERR_TMO;
          state_d = S_NEG;
        end
      end
      S_DATA: begin
        if (rd_q) begin
          if (op_q == OP_LONG) begin
            if (half_q) rdata_d[15:0]  = P_D_in;
            else        rdata_d[31:16] = P_D_in;
          end else if (op_q == OP_BYTE) begin
            rdata_d = {24'h0, rd_lane};
          end else begin
            rdata_d = {16'h0, P_D_in};
          end
        end
        state_d = S_NEG;
      end
      S_NEG:   state_d = S_RECOV;
      S_RECOV: begin
        if (P_DTACK_n && P_BERR_n) begin
          // Second half of a long follows without returning to IDLE, so no grant can split it.
          if ((op_q == OP_LONG) && !half_q && (err_q == ERR_OK)) begin
            half_d  = 1'b1;
            addr_d  = addr_q + ADDR_W'(2);
            state_d = S_ADDR;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_GRANT: if (!br_q && P_BGACK_n) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge C100 or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      br_q    <= 1'b0;
      op_q    <= OP_BYTE;
      rd_q    <= 1'b1;
      addr_q  <= '0;
      fc_q    <= '0;
      wdata_q <= '0;
      half_q  <= 1'b0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= !P_BR_n;
      op_q    <= op_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      fc_q    <= fc_d;
      wdata_q <= wdata_d;
      half_q  <= half_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign strobe    = state_q inside {S_ASRT, S_WAIT, S_DATA};
  assign P_bus_oe  = state_q inside {S_ADDR, S_ASRT, S_WAIT, S_DATA, S_NEG, S_RECOV};
  assign P_D_oe    = !rd_q && (state_q inside {S_ADDR, S_ASRT, S_WAIT, S_DATA, S_NEG});
  assign P_AS_n    = !strobe;
  assign P_UDS_n   = !(strobe && ((op_q != OP_BYTE) || !addr_q[0]));
  assign P_LDS_n   = !(strobe && ((op_q != OP_BYTE) || addr_q[0]));
  assign P_RW_n    = P_bus_oe ? rd_q : 1'b1;
  assign P_A       = addr_q[ADDR_W-1:1];
  assign P_FC      = fc_q;
  assign P_D_out   = (op_q == OP_BYTE) ? {wdata_q[7:0], wdata_q[7:0]} :
                     ((op_q == OP_LONG) && !half_q) ? wdata_q[31:16] : wdata_q[15:0];
  assign P_BG_n    = (state_q != S_GRANT);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid ? err_q : ERR_OK;
  assign rsp_data  = (rsp_valid && rd_q && (err_q == ERR_OK)) ? rdata_q : '0;

endmodule
